// File: rtl/difftest_pkg.sv
// difftest_pkg
//   Types and constants shared by the difftest commit channel.
//   - TRACE_XLEN     : pc / counter width carried by commit_entry_t
//   - EBREAK_FLAG    : value of out_flag when the presented entry is an ebreak
//   - commit_entry_t : one retired instruction as stored in the trace FIFO
//   - trace_state_e  : lifecycle of the trace (RUN -> DRAIN -> HALTED)
package difftest_pkg;

    localparam int TRACE_XLEN = 64;
    localparam logic [31:0] EBREAK_FLAG = 32'd1;

    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [31:0]           inst;
        logic                  skip;
        logic                  ebreak;
    } commit_entry_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } trace_state_e;

endpackage

// File: rtl/commit_trace_tx_if.sv
// commit_trace_tx_if
//   Bundles the writeback-side and reporter-side signals of commit_trace_tx.
//   master : the environment (writeback stage + DPI reporter)
//   slave  : commit_trace_tx
//
//   Handshake rule for both channels (wb_* and out_*): a transfer happens on a
//   rising clk edge where valid && ready. The sender keeps valid and its payload
//   stable until that edge; ready may change freely and never depends on valid.
interface commit_trace_tx_if #(
    parameter int XLEN = 64
);
    // writeback -> trace
    logic            wb_valid;
    logic            wb_ready;
    logic [XLEN-1:0] wb_pc;
    logic [31:0]     wb_inst;
    logic            wb_skip;
    logic            wb_ebreak;

    // trace -> DPI reporter
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [63:0]     out_inst;
    logic            out_skip;
    logic [31:0]     out_flag;

    // status
    logic [XLEN-1:0] commit_cnt;
    logic            halted;

    modport master (
        output wb_valid, wb_pc, wb_inst, wb_skip, wb_ebreak, out_ready,
        input  wb_ready, out_valid, out_pc, out_inst, out_skip, out_flag,
        input  commit_cnt, halted
    );

    modport slave (
        input  wb_valid, wb_pc, wb_inst, wb_skip, wb_ebreak, out_ready,
        output wb_ready, out_valid, out_pc, out_inst, out_skip, out_flag,
        output commit_cnt, halted
    );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with extra-MSB pointers; no bypass path, so data written
//   in one cycle is readable the next cycle at the earliest.
//   clk, rst : clock, asynchronous active-high reset (pointers only)
//   wr_en    : push wr_data (ignored while full)
//   rd_en    : pop the head (ignored while empty)
//   rd_data  : head entry, valid while !empty
//   full     : DEPTH entries held
//   empty    : no entries held
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    // Same slot index, opposite lap bit: the writer is a full lap ahead.
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + PTR_ONE;
            if (do_rd) rptr <= rptr + PTR_ONE;
        end
    end

    // Storage carries no reset; only slots behind the write pointer are ever read.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rptr[AW-1:0]];

endmodule

// File: rtl/commit_trace_tx.sv
// commit_trace_tx
//   Transmit side of the difftest commit channel. Retired instructions from
//   writeback are queued in a sync_fifo and presented in order to the DPI
//   reporter. Once an ebreak is accepted no further commits are taken; after
//   that ebreak is consumed the block halts until reset.
//   clk       : clock
//   rst       : asynchronous active-high reset
//   bus       : commit_trace_tx_if.slave (wb_* in, out_* out, commit_cnt, halted)
//   state_dbg : current trace state for observation
//   XLEN must equal difftest_pkg::TRACE_XLEN (width of commit_entry_t.pc).
module commit_trace_tx
    import difftest_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = TRACE_XLEN
) (
    input  logic                    clk,
    input  logic                    rst,
    commit_trace_tx_if.slave        bus,
    output trace_state_e            state_dbg
);
    localparam logic [XLEN-1:0] CNT_ONE = XLEN'(1);

    trace_state_e    state;
    logic [XLEN-1:0] cnt_q;
    commit_entry_t   wr_entry;
    commit_entry_t   head;
    logic            full;
    logic            empty;
    logic            enq;
    logic            deq;

    assign bus.wb_ready  = (state == RUN) && !full;
    assign bus.out_valid = !empty && (state != HALTED);

    assign enq = bus.wb_valid && bus.wb_ready;
    assign deq = bus.out_valid && bus.out_ready;

    always_comb begin
        wr_entry        = '0;
        wr_entry.pc     = bus.wb_pc;
        wr_entry.inst   = bus.wb_inst;
        wr_entry.skip   = bus.wb_skip;
        wr_entry.ebreak = bus.wb_ebreak;
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(commit_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (enq),
        .wr_data (wr_entry),
        .rd_en   (deq),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // Payload is forced to zero while nothing is presented so stale storage
    // never leaks onto the reporter bus (and outputs read 0 out of reset).
    assign bus.out_pc   = bus.out_valid ? head.pc : '0;
    assign bus.out_inst = bus.out_valid ? {32'd0, head.inst} : 64'd0;
    assign bus.out_skip = bus.out_valid && head.skip;
    assign bus.out_flag = (bus.out_valid && head.ebreak) ? EBREAK_FLAG : 32'd0;

    // Trace lifecycle and commit counter. The ebreak is always the youngest
    // entry once DRAIN is entered, so its dequeue empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt_q <= '0;
        end else begin
            if (deq) cnt_q <= cnt_q + CNT_ONE;
            case (state)
                RUN:     if (enq && bus.wb_ebreak) state <= DRAIN;
                DRAIN:   if (deq && head.ebreak)   state <= HALTED;
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    assign bus.commit_cnt = cnt_q;
    assign bus.halted     = (state == HALTED);
    assign state_dbg      = state;

endmodule

// File: tb/tb_commit_trace_tx.sv
module tb_commit_trace_tx;
    import difftest_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int W     = XLEN + 32 + 2;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    trace_state_e state_dbg;

    always #5 clk = ~clk;

    commit_trace_tx_if #(.XLEN(XLEN)) bus();

    commit_trace_tx #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0]    exp_q[$];   // entries the block should hold, oldest first
    logic [W-1:0]    drv_q[$];   // commits waiting to be offered by writeback
    bit              m_stop;     // an ebreak has been accepted
    bit              m_done;     // the ebreak has been consumed
    logic [XLEN-1:0] m_cnt;
    int              rdy_mode;   // 0: out_ready low, 1: high, 2: random

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [63:0] pc, input logic [31:0] inst,
                                        input bit skip, input bit eb);
        return {pc, inst, skip, eb};
    endfunction

    function automatic logic [W-1:0] rnd_commit(input bit eb);
        logic [63:0] pc;
        pc = {32'h0000_0000, 32'h8000_0000 | ($urandom_range(0, 4095) << 2)};
        return mk(pc, $urandom, bit'($urandom_range(0, 1)), eb);
    endfunction

    // ---------------- driver tasks ----------------
    // One clock cycle, entered and left at a negedge: drive inputs, compare
    // outputs with the model, advance the model on the posedge.
    task automatic step();
        logic [W-1:0] head;
        logic [W-1:0] e;
        bit           exp_ready;
        bit           exp_valid;
        bit           offer;
        exp_ready = !m_stop && (exp_q.size() < DEPTH);
        exp_valid = (exp_q.size() > 0) && !m_done;
        offer     = (drv_q.size() > 0);

        bus.wb_valid = offer;
        if (offer) begin
            {bus.wb_pc, bus.wb_inst, bus.wb_skip, bus.wb_ebreak} = drv_q[0];
        end else begin
            // junk on an idle bus must be ignored
            bus.wb_pc     = {$urandom, $urandom};
            bus.wb_inst   = $urandom;
            bus.wb_skip   = 1'($urandom_range(0, 1));
            bus.wb_ebreak = 1'($urandom_range(0, 1));
        end
        case (rdy_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        check("wb_ready",   64'(bus.wb_ready),   64'(exp_ready));
        check("out_valid",  64'(bus.out_valid),  64'(exp_valid));
        check("halted",     64'(bus.halted),     64'(m_done));
        check("commit_cnt", 64'(bus.commit_cnt), 64'(m_cnt));
        if (exp_valid) begin
            head = exp_q[0];
            check("out_pc",   64'(bus.out_pc),   head[W-1 -: 64]);
            check("out_inst", bus.out_inst,      {32'd0, head[33:2]});
            check("out_skip", 64'(bus.out_skip), 64'(head[1]));
            check("out_flag", 64'(bus.out_flag), head[0] ? 64'd1 : 64'd0);
        end

        @(posedge clk);
        if (exp_valid && bus.out_ready) begin
            e = exp_q.pop_front();
            m_cnt++;
            if (e[0]) m_done = 1'b1;
        end
        if (offer && exp_ready) begin
            e = drv_q.pop_front();
            exp_q.push_back(e);
            if (e[0]) m_stop = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input int mode);
        rdy_mode = mode;
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any clock.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_out_valid",  64'(bus.out_valid),  64'd0);
        check("rst_commit_cnt", 64'(bus.commit_cnt), 64'd0);
        check("rst_halted",     64'(bus.halted),     64'd0);
        check("rst_out_pc",     64'(bus.out_pc),     64'd0);
        check("rst_out_flag",   64'(bus.out_flag),   64'd0);
        exp_q.delete();
        drv_q.delete();
        m_cnt  = '0;
        m_stop = 1'b0;
        m_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.wb_valid  = 1'b0;
        bus.wb_pc     = '0;
        bus.wb_inst   = '0;
        bus.wb_skip   = 1'b0;
        bus.wb_ebreak = 1'b0;
        bus.out_ready = 1'b0;
        rdy_mode      = 0;
        @(negedge clk);
        do_reset();

        // 1: three back-to-back commits, reporter always ready
        drv_q.push_back(mk(64'h8000_0000, $urandom, 1'b0, 1'b0));
        drv_q.push_back(mk(64'h8000_0004, $urandom, 1'b0, 1'b0));
        drv_q.push_back(mk(64'h8000_0008, $urandom, 1'b0, 1'b0));
        run(6, 1);
        check("t1_commit_cnt", 64'(bus.commit_cnt), 64'd3);

        // 2: reporter stalled, five commits; the fifth must wait
        for (int i = 0; i < 5; i++) drv_q.push_back(rnd_commit(1'b0));
        run(6, 0);
        check("t2_wb_ready_full", 64'(bus.wb_ready), 64'd0);
        run(1, 1);
        run(2, 0);
        check("t2_refilled", 64'(bus.wb_ready), 64'd0);
        run(6, 1);
        check("t2_drained", 64'(bus.out_valid), 64'd0);

        // 3: full FIFO with both sides active for 20 cycles
        for (int i = 0; i < 24; i++) drv_q.push_back(rnd_commit(1'b0));
        run(4, 0);
        check("t3_full", 64'(bus.wb_ready), 64'd0);
        run(20, 1);
        run(12, 1);

        // 4: A, B, ebreak E, then C which must be refused
        do_reset();
        drv_q.push_back(rnd_commit(1'b0));
        drv_q.push_back(rnd_commit(1'b0));
        drv_q.push_back(mk(64'h8000_0100, 32'h0010_0073, 1'b0, 1'b1));
        drv_q.push_back(rnd_commit(1'b0));
        run(5, 0);
        check("t4_c_refused", 64'(bus.wb_ready), 64'd0);
        run(4, 1);
        check("t4_halted", 64'(bus.halted),     64'd1);
        check("t4_cnt",    64'(bus.commit_cnt), 64'd3);
        check("t4_no_out", 64'(bus.out_valid),  64'd0);

        // 5: reset with two entries queued, then normal operation
        do_reset();
        drv_q.push_back(rnd_commit(1'b0));
        drv_q.push_back(rnd_commit(1'b0));
        run(3, 0);
        check("t5_queued", 64'(bus.out_valid), 64'd1);
        do_reset();
        drv_q.push_back(rnd_commit(1'b0));
        run(3, 1);
        check("t5_cnt", 64'(bus.commit_cnt), 64'd1);

        // 6: MMIO skip commit carrying the ebreak encoding but ebreak=0
        drv_q.push_back(mk(64'h8000_0200, 32'h0010_0073, 1'b1, 1'b0));
        run(2, 0);
        check("t6_skip", 64'(bus.out_skip), 64'd1);
        check("t6_inst", bus.out_inst,      64'h0000_0000_0010_0073);
        check("t6_flag", 64'(bus.out_flag), 64'd0);
        run(2, 1);

        // random traffic with occasional ebreaks and restarts
        for (int c = 0; c < 600; c++) begin
            if (m_done && $urandom_range(0, 3) == 0) do_reset();
            if (drv_q.size() < 3 && $urandom_range(0, 1) == 1)
                drv_q.push_back(rnd_commit(bit'($urandom_range(0, 39) == 0)));
            run(1, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
